// File: rtl/lsu_defs_pkg.sv
// Shared load/store type codes, FSM encoding and access legality check
// for the load/store memory sequencer.
package lsu_defs;

  localparam logic [2:0] LT_LW   = 3'd0;
  localparam logic [2:0] LT_LBU  = 3'd1;
  localparam logic [2:0] LT_LB   = 3'd2;
  localparam logic [2:0] LT_LHU  = 3'd4;
  localparam logic [2:0] LT_LH   = 3'd5;
  localparam logic [2:0] LT_NONE = 3'd7;

  localparam logic [1:0] ST_SW   = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_NONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_WAIT_RD  = 2'd2,
    S_FIN      = 2'd3
  } lsu_state_e;

  // True when exactly one of load/store is requested, the type is defined
  // and the address is naturally aligned for the access size.
  function automatic logic access_ok(input logic       ld,
                                     input logic       st,
                                     input logic [2:0] lt,
                                     input logic [1:0] sty,
                                     input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (ld && !st) begin
      case (lt)
        LT_LW:         ok = (a == 2'b00);
        LT_LB, LT_LBU: ok = 1'b1;
        LT_LH, LT_LHU: ok = !a[0];
        default:       ok = 1'b0;
      endcase
    end else if (st && !ld) begin
      case (sty)
        ST_SW:   ok = (a == 2'b00);
        ST_SB:   ok = 1'b1;
        ST_SH:   ok = !a[0];
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated store data on the way out,
// lane extraction and sign/zero extension of load data on the way back.
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic        is_store,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [15:0] shifted;

  assign shifted = 16'(rdata_word >> {addr_lo, 3'b000});

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata_word;
    if (is_store) begin
      case (store_type)
        ST_SB: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        ST_SH: begin
          be         = 4'b0011 << addr_lo;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end else begin
      case (load_type)
        LT_LB: begin
          be        = 4'b0001 << addr_lo;
          rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
        end
        LT_LBU: begin
          be        = 4'b0001 << addr_lo;
          rdata_ext = {24'd0, shifted[7:0]};
        end
        LT_LH: begin
          be        = 4'b0011 << addr_lo;
          rdata_ext = {{16{shifted[15]}}, shifted};
        end
        LT_LHU: begin
          be        = 4'b0011 << addr_lo;
          rdata_ext = {16'd0, shifted};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// One data-memory access per instruction over a req/gnt/rvalid port, with
// stall, completion pulse, error reporting and an access timeout.
module lsu_mem_sequencer
  import lsu_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        load_type,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              st_q, err_q, err_d;
  logic [2:0]        lt_q;
  logic [1:0]        sty_q;
  logic              capture, load_rd, legal, timeout_hit;
  logic [3:0]        be;
  logic [31:0]       wdata_lane, rdata_ext;

  assign legal       = access_ok(is_load, is_store, load_type, store_type, addr[1:0]);
  assign timeout_hit = (cnt_q == TO_LAST);

  lsu_lane_align u_align (
    .is_store   (st_q),
    .load_type  (lt_q),
    .store_type (sty_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata_word (mem_rdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      st_q    <= 1'b0;
      lt_q    <= LT_NONE;
      sty_q   <= ST_NONE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        st_q    <= is_store;
        lt_q    <= load_type;
        sty_q   <= store_type;
      end
      if (load_rd) rdata_q <= rdata_ext;
    end
  end

  // A real response in the same cycle as the timeout wins over the abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    err_d   = err_q;
    capture = 1'b0;
    load_rd = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (start) begin
          capture = 1'b1;
          if (legal) begin
            stall   = 1'b1;
            state_d = S_WAIT_GNT;
            err_d   = 1'b0;
          end else begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end
        end
      end
      S_WAIT_GNT: begin
        stall = 1'b1;
        if (mem_gnt) begin
          cnt_d   = 8'd0;
          state_d = st_q ? S_FIN : S_WAIT_RD;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end
      end
      S_WAIT_RD: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          load_rd = 1'b1;
          state_d = S_FIN;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end
      end
      S_FIN: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req   = (state_q == S_WAIT_GNT);
  assign mem_we    = mem_req & st_q;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be : 4'd0;
  assign mem_wdata = mem_we ? wdata_lane : 32'd0;
  assign done      = (state_q == S_FIN);
  assign err       = done & err_q;
  assign rdata     = rdata_q;

endmodule
